imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader: the write side of the instruction memory that the single-cycle CPU reads through its program counter. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. It holds the CPU in reset until the declared program is fully loaded.

## Interface
- DEPTH, 128: instruction memory depth in 32-bit words; writes at word index >= DEPTH are suppressed.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be word-aligned.

- clk_i  in  1  single clock, all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- restart_i  in  1  synchronous pulse: abandon or finish the current load and rearm at header
- byte_valid_i  in  1  stream byte valid
- byte_data_i  in  8  stream byte
- byte_ready_o  out  1  loader can accept a byte this cycle
- imem_we_o  out  1  instruction memory write strobe, one-cycle pulse
- imem_addr_o  out  32  byte address of the write, always word-aligned
- imem_data_o  out  32  instruction word
- cpu_rst_o  out  1  active-low reset to the CPU; 0 holds the CPU
- busy_o  out  1  load in progress
- overflow_o  out  1  sticky: declared word count exceeded DEPTH
- chk_err_o  out  1  sticky: checksum mismatch (0 when checksum not compiled in)
- words_loaded_o  out  16  words accepted in the current load

## Operation
- Byte transfer happens on a rising edge where byte_valid_i && byte_ready_o. byte_data_i is ignored otherwise.
- FSM states: HDR_HI, HDR_LO, LOAD, CHK (only with the macro), DONE.
- HDR_HI: capture N[15:8], then go to HDR_LO.
- HDR_LO: capture N[7:0]. If N==0, go to CHK/DONE; otherwise go to LOAD.
- LOAD: shift bytes into the word register MSB-first (the first byte becomes bits [31:24]). On the 4th byte:
  - issue a write and increment words_loaded_o;
  - when words_loaded_o reaches N, go to CHK/DONE.
- Write address is BASE_ADDR + 4*k, where k is the word index (0-based), computed as 32-bit wrapping arithmetic.
- If N > DEPTH, overflow_o is set when the header completes. Words with k >= DEPTH are still consumed and counted, but imem_we_o is not pulsed for them.
- DONE: byte_ready_o=0 and busy_o=0. cpu_rst_o=1 unless chk_err_o is set.
- restart_i in any state returns the FSM to HDR_HI on the next edge and clears N, the byte phase, words_loaded_o, overflow_o and chk_err_o. cpu_rst_o drops to 0 on that edge.
- restart_i coinciding with a byte transfer: restart wins and the byte is dropped.
- Stream stall (byte_valid_i low) in any state: hold all state; no timeout.

## Timing
- Reset values: byte_ready_o=0, imem_we_o=0, imem_addr_o=BASE_ADDR, imem_data_o=0, cpu_rst_o=0, busy_o=0, overflow_o=0, chk_err_o=0, words_loaded_o=0. The FSM resets to HDR_HI.
- First cycle after reset release: byte_ready_o=1 and busy_o=1. byte_ready_o is 1 in every state except DONE.
- All outputs are registered.
- imem_we_o, imem_addr_o and imem_data_o are valid the cycle after the edge that accepts the 4th byte of a word. They are a 1-cycle pulse; address and data then hold until the next write.
- Back-to-back bytes are accepted every cycle. Peak rate is one word per 4 cycles.
- cpu_rst_o rises on the edge that enters DONE:
  - with the macro off, this is the same edge that accepts the last data byte;
  - it therefore rises in the same cycle that the final imem_we_o pulse is visible;
  - the CPU's first fetch occurs at least one edge after the last write.
- Asynchronous reset mid-load: all state is lost immediately and outputs take their reset values. Memory contents already written are untouched.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - after the last data byte (or after the header when N==0), the FSM enters CHK and accepts one byte;
  - that byte is compared with the XOR of all data bytes of this load;
  - on mismatch, chk_err_o=1 and cpu_rst_o stays 0 in DONE;
  - cpu_rst_o rises on the edge accepting the checksum byte when it matches.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHK state, no accumulator, chk_err_o tied 0.

## Test plan
- Header 00 02, bytes 20 08 00 05 / 01 09 50 20, macro off:
  - writes 32'h20080005 at addr 0, then 32'h01095020 at addr 4;
  - words_loaded_o=2;
  - cpu_rst_o rises together with the second write pulse.
- Same stream with byte_valid_i deasserted for 3 cycles between every byte:
  - identical writes;
  - exactly two imem_we_o pulses;
  - no byte lost or duplicated.
- DEPTH=2, header 00 03, 12 bytes:
  - overflow_o=1 after the header;
  - exactly two writes, at 0 and 4;
  - words_loaded_o=3;
  - DONE reached.
- Header 00 00:
  - DONE after 2 bytes (3 with the macro, checksum 00);
  - no write;
  - cpu_rst_o=1.
- Macro on, one word AA 55 0F F0 followed by checksum 00 -> chk_err_o=0, cpu_rst_o=1. Followed by checksum 01 instead -> chk_err_o=1, cpu_rst_o=0.
- Reset and restart mid-word:
  - rst_i low after 2 bytes of word 1 -> outputs at reset values immediately;
  - restart_i in DONE -> cpu_rst_o=0 next edge, reload of 00 01 11 22 33 44 writes 32'h11223344 at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// It receives a byte stream over a valid/ready handshake. The stream starts with a
// big-endian 16-bit word count N, followed by N big-endian 32-bit instruction words.
// Each word is written to BASE_ADDR + 4*k. The CPU is held in reset until the load
// completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to make the loader expect one
// trailing checksum byte, which is the XOR of all data bytes in the load.
module imem_loader #(
    parameter int unsigned DEPTH     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        restart_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        chk_err_o,
    output logic [15:0] words_loaded_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR_HI, HDR_LO, LOAD, CHK, DONE} state_t;
    // The last data byte, or an empty header, leads to the checksum byte.
    localparam state_t END_ST = CHK;
`else
    typedef enum logic [1:0] {HDR_HI, HDR_LO, LOAD, DONE} state_t;
    localparam state_t END_ST = DONE;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [15:0] count_nxt;
    logic [1:0]  phase;
    logic [1:0]  phase_nxt;
    logic [23:0] shift;
    logic [23:0] shift_nxt;
    logic [15:0] words_nxt;
    logic        ready_nxt;
    logic        we_nxt;
    logic        cpu_rst_nxt;
    logic        busy_nxt;
    logic        ovf_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] data_nxt;

    logic        xfer;
    logic [15:0] hdr_word;
    logic [15:0] words_inc;
    logic [31:0] word_addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  acc;
    logic [7:0]  acc_nxt;
    logic        chk_err;
    logic        chk_err_nxt;
    assign chk_err_o = chk_err;
`else
    assign chk_err_o = 1'b0;
`endif

    // A byte is consumed only when the registered ready matches a valid byte.
    assign xfer      = byte_valid_i & byte_ready_o;
    assign hdr_word  = {count[15:8], byte_data_i};
    assign words_inc = words_loaded_o + 16'd1;
    // Wrapping 32-bit byte address of the word that is being completed.
    assign word_addr = BASE_ADDR + {14'd0, words_loaded_o, 2'b00};

    // Next-state and next-output logic; restart overrides any byte transfer.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        phase_nxt = phase;
        shift_nxt = shift;
        words_nxt = words_loaded_o;
        we_nxt    = 1'b0;
        addr_nxt  = imem_addr_o;
        data_nxt  = imem_data_o;
        ovf_nxt   = overflow_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_nxt     = acc;
        chk_err_nxt = chk_err;
`endif
        if (restart_i) begin
            state_nxt = HDR_HI;
            count_nxt = 16'd0;
            phase_nxt = 2'd0;
            words_nxt = 16'd0;
            ovf_nxt   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_nxt     = 8'd0;
            chk_err_nxt = 1'b0;
`endif
        end else if (xfer) begin
            case (state)
                HDR_HI: begin
                    count_nxt = {byte_data_i, count[7:0]};
                    state_nxt = HDR_LO;
                end
                HDR_LO: begin
                    count_nxt = hdr_word;
                    ovf_nxt   = ({16'd0, hdr_word} > DEPTH);
                    state_nxt = (hdr_word == 16'd0) ? END_ST : LOAD;
                end
                LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_nxt = acc ^ byte_data_i;
`endif
                    if (phase == 2'd3) begin
                        // The fourth byte completes the word. Words beyond DEPTH are
                        // counted but not written.
                        we_nxt    = ({16'd0, words_loaded_o} < DEPTH);
                        addr_nxt  = word_addr;
                        data_nxt  = {shift, byte_data_i};
                        words_nxt = words_inc;
                        phase_nxt = 2'd0;
                        if (words_inc == count) begin
                            state_nxt = END_ST;
                        end
                    end else begin
                        shift_nxt = {shift[15:0], byte_data_i};
                        phase_nxt = phase + 2'd1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    chk_err_nxt = (byte_data_i != acc);
                    state_nxt   = DONE;
                end
`endif
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = HDR_HI;
                end
            endcase
        end

        ready_nxt = (state_nxt != DONE);
        busy_nxt  = (state_nxt != DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        cpu_rst_nxt = (state_nxt == DONE) && !chk_err_nxt;
`else
        cpu_rst_nxt = (state_nxt == DONE);
`endif
    end

    // State and registered outputs. Asynchronous reset clears everything at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= HDR_HI;
            count          <= 16'd0;
            phase          <= 2'd0;
            shift          <= 24'd0;
            words_loaded_o <= 16'd0;
            byte_ready_o   <= 1'b0;
            imem_we_o      <= 1'b0;
            imem_addr_o    <= BASE_ADDR;
            imem_data_o    <= 32'd0;
            cpu_rst_o      <= 1'b0;
            busy_o         <= 1'b0;
            overflow_o     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc            <= 8'd0;
            chk_err        <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            phase          <= phase_nxt;
            shift          <= shift_nxt;
            words_loaded_o <= words_nxt;
            byte_ready_o   <= ready_nxt;
            imem_we_o      <= we_nxt;
            imem_addr_o    <= addr_nxt;
            imem_data_o    <= data_nxt;
            cpu_rst_o      <= cpu_rst_nxt;
            busy_o         <= busy_nxt;
            overflow_o     <= ovf_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc            <= acc_nxt;
            chk_err        <= chk_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// Two loaders share the same stimulus. Instance a uses DEPTH=2 and BASE 0.
// Instance b uses DEPTH=128 and BASE 0x1000.
// Expected writes come from decoding the byte stream directly into a queue of words.
// Every write pulse is compared against the front of that queue.
module tb_imem_loader;

    localparam int          DEPTH_A = 2;
    localparam int          DEPTH_B = 128;
    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam logic [31:0] BASE_B  = 32'h0000_1000;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        int          k;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;

    logic        ready_a, we_a, cpu_rst_a, busy_a, ovf_a, chk_err_a;
    logic [31:0] addr_a, data_a;
    logic [15:0] words_a;
    logic        ready_b, we_b, cpu_rst_b, busy_b, ovf_b, chk_err_b;
    logic [31:0] addr_b, data_b;
    logic [15:0] words_b;

    int checks = 0;
    int failures = 0;
    int we_cnt_a = 0;
    int we_cnt_b = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t log_a[$];
    wr_t log_b[$];
    logic [7:0] stream[$];
    wr_t ga, gb, ea, eb;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH_A), .BASE_ADDR(BASE_A)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .restart_i(restart),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .byte_ready_o(ready_a), .imem_we_o(we_a), .imem_addr_o(addr_a),
        .imem_data_o(data_a), .cpu_rst_o(cpu_rst_a), .busy_o(busy_a),
        .overflow_o(ovf_a), .chk_err_o(chk_err_a), .words_loaded_o(words_a)
    );

    imem_loader #(.DEPTH(DEPTH_B), .BASE_ADDR(BASE_B)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .restart_i(restart),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .byte_ready_o(ready_b), .imem_we_o(we_b), .imem_addr_o(addr_b),
        .imem_data_o(data_b), .cpu_rst_o(cpu_rst_b), .busy_o(busy_b),
        .overflow_o(ovf_b), .chk_err_o(chk_err_b), .words_loaded_o(words_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Compare every write pulse against the model's queue of expected writes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_a) begin
                we_cnt_a++;
                ga.addr = addr_a; ga.data = data_a; ga.last = 1'b0; ga.k = 0;
                log_a.push_back(ga);
                if (exp_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL write_a_unexpected got addr=%h data=%h expected no write", addr_a, data_a);
                end else begin
                    ea = exp_a.pop_front();
                    check("write_a_addr", addr_a, ea.addr);
                    check("write_a_data", data_a, ea.data);
                    check("write_a_words", 32'(words_a), 32'(ea.k));
                    check("write_a_cpu_rst", 32'(cpu_rst_a), 32'(ea.last && !CHK_EN));
                end
            end
            if (we_b) begin
                we_cnt_b++;
                gb.addr = addr_b; gb.data = data_b; gb.last = 1'b0; gb.k = 0;
                log_b.push_back(gb);
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL write_b_unexpected got addr=%h data=%h expected no write", addr_b, data_b);
                end else begin
                    eb = exp_b.pop_front();
                    check("write_b_addr", addr_b, eb.addr);
                    check("write_b_data", data_b, eb.data);
                    check("write_b_words", 32'(words_b), 32'(eb.k));
                    check("write_b_cpu_rst", 32'(cpu_rst_b), 32'(eb.last && !CHK_EN));
                end
            end
        end
    end

    // Called at a negedge. Offers one byte, waits for the handshake edge, then
    // idles for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!ready_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready_a) begin
            checks++; failures++;
            $display("FAIL handshake_timeout got ready=0 expected ready=1 within 50 cycles");
            byte_valid = 1'b0;
        end else begin
            @(negedge clk);
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic push_hdr(input logic [15:0] n);
        stream.delete();
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Decode the stream into expected writes, send it, and check the final load status.
    task automatic run_load(input int gap, input bit bad_chk);
        int n, nw_a, nw_b;
        logic [7:0] x;
        wr_t e;
        bit exp_err;
        n = int'({stream[0], stream[1]});
        x = 8'h00;
        log_a.delete();
        log_b.delete();
        for (int k = 0; k < n; k++) begin
            e.data = {stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]};
            x = x ^ stream[2+4*k] ^ stream[3+4*k] ^ stream[4+4*k] ^ stream[5+4*k];
            e.last = (k == n - 1);
            e.k = k + 1;
            e.addr = BASE_A + 32'(4 * k);
            if (k < DEPTH_A) exp_a.push_back(e);
            e.addr = BASE_B + 32'(4 * k);
            if (k < DEPTH_B) exp_b.push_back(e);
        end
        nw_a = (n < DEPTH_A) ? n : DEPTH_A;
        nw_b = (n < DEPTH_B) ? n : DEPTH_B;
        we_cnt_a = 0;
        we_cnt_b = 0;
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], gap);
            if (i == 1) begin
                check("overflow_a_after_hdr", 32'(ovf_a), 32'(n > DEPTH_A));
                check("overflow_b_after_hdr", 32'(ovf_b), 32'(n > DEPTH_B));
            end
        end
        exp_err = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, bad_chk}, gap);
        exp_err = bad_chk;
`else
        if (bad_chk) exp_err = 1'b0;
`endif
        @(negedge clk);
        check("words_a", 32'(words_a), 32'(n));
        check("words_b", 32'(words_b), 32'(n));
        check("busy_done", 32'(busy_a), 32'd0);
        check("ready_done", 32'(ready_a), 32'd0);
        check("cpu_rst_done", 32'(cpu_rst_a), 32'(!exp_err));
        check("cpu_rst_b_done", 32'(cpu_rst_b), 32'(!exp_err));
        check("chk_err_done", 32'(chk_err_a), 32'(exp_err));
        check("pulses_a", 32'(we_cnt_a), 32'(nw_a));
        check("pulses_b", 32'(we_cnt_b), 32'(nw_b));
        check("pending_a", 32'(exp_a.size()), 32'd0);
        check("pending_b", 32'(exp_b.size()), 32'd0);
    endtask

    task automatic do_restart(input bit with_byte);
        restart    = 1'b1;
        byte_valid = with_byte;
        byte_data  = 8'hC3;
        @(negedge clk);
        restart    = 1'b0;
        byte_valid = 1'b0;
        check("restart_cpu_rst", 32'(cpu_rst_a), 32'd0);
        check("restart_busy", 32'(busy_a), 32'd1);
        check("restart_ready", 32'(ready_a), 32'd1);
        check("restart_words", 32'(words_a), 32'd0);
        check("restart_overflow", 32'(ovf_a), 32'd0);
        check("restart_chk_err", 32'(chk_err_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_addr_a", addr_a, BASE_A);
        check("rst_addr_b", addr_b, BASE_B);
        check("rst_data", data_a, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_words", 32'(words_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_cycle_ready", 32'(ready_a), 32'd1);
        check("first_cycle_busy", 32'(busy_a), 32'd1);

        // Two-word program with back-to-back bytes.
        push_hdr(16'd2);
        push_word(32'h2008_0005);
        push_word(32'h0109_5020);
        run_load(0, 1'b0);
        if (log_a.size() == 2) begin
            check("lit_w0_data", log_a[0].data, 32'h2008_0005);
            check("lit_w0_addr", log_a[0].addr, 32'h0000_0000);
            check("lit_w1_data", log_a[1].data, 32'h0109_5020);
            check("lit_w1_addr", log_a[1].addr, 32'h0000_0004);
        end else begin
            check("lit_log_a_size", 32'(log_a.size()), 32'd2);
        end
        if (log_b.size() == 2) begin
            check("lit_b_w1_addr", log_b[1].addr, 32'h0000_1004);
        end else begin
            check("lit_log_b_size", 32'(log_b.size()), 32'd2);
        end

        // The same program with a three-cycle stall between bytes.
        do_restart(1'b0);
        run_load(3, 1'b0);

        // Three words declared. Instance a only writes its first two words.
        do_restart(1'b0);
        push_hdr(16'd3);
        push_word(32'hDEAD_BEEF);
        push_word(32'h0123_4567);
        push_word(32'hCAFE_F00D);
        run_load(0, 1'b0);
        check("lit_overflow_a", 32'(ovf_a), 32'd1);
        if (log_a.size() == 2) begin
            check("lit_ovf_w1_addr", log_a[1].addr, 32'h0000_0004);
        end else begin
            check("lit_ovf_log_size", 32'(log_a.size()), 32'd2);
        end

        // Empty program.
        do_restart(1'b0);
        push_hdr(16'd0);
        run_load(0, 1'b0);

        // Restart from DONE, then abandon a partial word with a restart that
        // coincides with an offered byte.
        check("done_cpu_rst_high", 32'(cpu_rst_a), 32'd1);
        do_restart(1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h77, 0);
        do_restart(1'b1);
        push_hdr(16'd1);
        push_word(32'h1122_3344);
        run_load(0, 1'b0);
        if (log_a.size() == 1) begin
            check("lit_reload_data", log_a[0].data, 32'h1122_3344);
            check("lit_reload_addr", log_a[0].addr, BASE_A);
            check("lit_reload_addr_b", log_b[0].addr, BASE_B);
        end else begin
            check("lit_reload_log_size", 32'(log_a.size()), 32'd1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum tests: the good byte is 00, and 01 is a mismatch.
        do_restart(1'b0);
        push_hdr(16'd1);
        push_word(32'hAA55_0FF0);
        run_load(0, 1'b0);
        check("lit_chk_ok_err", 32'(chk_err_a), 32'd0);
        do_restart(1'b0);
        push_hdr(16'd1);
        push_word(32'hAA55_0FF0);
        run_load(0, 1'b1);
        check("lit_chk_bad_err", 32'(chk_err_a), 32'd1);
        check("lit_chk_bad_cpu_rst", 32'(cpu_rst_a), 32'd0);
`endif

        // Asynchronous reset after two bytes of the first word.
        do_restart(1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready_a), 32'd0);
        check("async_rst_busy", 32'(busy_a), 32'd0);
        check("async_rst_words", 32'(words_a), 32'd0);
        check("async_rst_data", data_a, 32'd0);
        check("async_rst_addr_b", addr_b, BASE_B);
        check("async_rst_cpu_rst", 32'(cpu_rst_a), 32'd0);
        check("async_rst_overflow", 32'(ovf_a), 32'd0);
        check("async_rst_we", 32'(we_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_a), 32'd1);
        check("post_rst_busy", 32'(busy_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
